// File: rtl/ascon_round_ctrl.sv
// rtl/ascon_round_ctrl.sv - Iterative Ascon permutation sequencer driving an external round datapath.
// Optional: ASCON_ROUND_CTRL_BACK2BACK_EN lets a new start be accepted in the same cycle as the done handshake.
module ascon_round_ctrl #(
  parameter int NUM_ROUNDS_FULL    = 12,
  parameter int NUM_ROUNDS_REDUCED = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_valid_i,
  output logic         start_ready_o,
  input  logic         round_config_i,
  input  logic [319:0] state_i,
  output logic [3:0]   rnd_o,
  output logic         round_config_o,
  output logic [319:0] round_state_o,
  input  logic [319:0] round_state_i,
  output logic         done_valid_o,
  input  logic         done_ready_i,
  output logic [319:0] state_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_FULL    = 4'(NUM_ROUNDS_FULL - 1);
  localparam logic [3:0] LAST_REDUCED = 4'(NUM_ROUNDS_REDUCED - 1);

  fsm_t         fsm_q;
  logic [319:0] state_q;
  logic [3:0]   rnd_q;
  logic         cfg_q;
  logic         ready_q;
  logic         done_q;
  logic         busy_q;
  logic [3:0]   rnd_last;

  assign rnd_last = cfg_q ? LAST_FULL : LAST_REDUCED;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      cfg_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_valid_i) begin
            state_q <= state_i;
            cfg_q   <= round_config_i;
            rnd_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= round_state_i;
          if (rnd_q == rnd_last) begin
            rnd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            fsm_q  <= DONE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        DONE: begin
          if (done_ready_i) begin
            done_q <= 1'b0;
`ifdef ASCON_ROUND_CTRL_BACK2BACK_EN
            // Done and start handshakes in one cycle: reload and restart with no bubble.
            if (start_valid_i) begin
              state_q <= state_i;
              cfg_q   <= round_config_i;
              rnd_q   <= '0;
              busy_q  <= 1'b1;
              fsm_q   <= RUN;
            end else begin
              ready_q <= 1'b1;
              fsm_q   <= IDLE;
            end
`else
            ready_q <= 1'b1;
            fsm_q   <= IDLE;
`endif
          end
        end
        default: begin
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          fsm_q   <= IDLE;
        end
      endcase
    end
  end

`ifdef ASCON_ROUND_CTRL_BACK2BACK_EN
  assign start_ready_o = ready_q | (done_q & done_ready_i);
`else
  assign start_ready_o = ready_q;
`endif

  assign done_valid_o   = done_q;
  assign busy_o         = busy_q;
  assign rnd_o          = rnd_q;
  assign round_config_o = cfg_q;
  assign round_state_o  = state_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// tb/tb_ascon_round_ctrl.sv - Directed self-checking bench for ascon_round_ctrl with a counting datapath stub.
module tb_ascon_round_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_valid_i;
  logic         start_ready_o;
  logic         round_config_i;
  logic [319:0] state_i;
  logic [3:0]   rnd_o;
  logic         round_config_o;
  logic [319:0] round_state_o;
  logic [319:0] round_state_i;
  logic         done_valid_o;
  logic         done_ready_i;
  logic [319:0] state_o;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  // Stub: word0 += 1, word1 ^= round index, upper words pass through.
  assign round_state_i = {round_state_o[319:128],
                          round_state_o[127:64] ^ {60'b0, rnd_o},
                          round_state_o[63:0] + 64'd1};

  ascon_round_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_valid_i  (start_valid_i),
    .start_ready_o  (start_ready_o),
    .round_config_i (round_config_i),
    .state_i        (state_i),
    .rnd_o          (rnd_o),
    .round_config_o (round_config_o),
    .round_state_o  (round_state_o),
    .round_state_i  (round_state_i),
    .done_valid_o   (done_valid_o),
    .done_ready_i   (done_ready_i),
    .state_o        (state_o),
    .busy_o         (busy_o)
  );

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, start_ready_o, 1);
    check({tag, "_done"}, done_valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_rnd"}, rnd_o, 0);
    check({tag, "_cfg"}, round_config_o, 0);
    check({tag, "_rstate"}, round_state_o, 0);
    check({tag, "_state"}, state_o, 0);
  endtask

  // Called at a negedge while idle; returns at the negedge after DONE is entered.
  task automatic run_perm(input logic cfg, input logic [319:0] init, input logic toggle,
                          output logic [319:0] exp);
    int r;
    r = cfg ? 12 : 8;
    check("idle_ready", start_ready_o, 1);
    start_valid_i  = 1'b1;
    round_config_i = cfg;
    state_i        = init;
    @(negedge clk_i);
    start_valid_i = 1'b0;
    state_i       = '0;
    exp           = init;
    for (int k = 0; k < r; k++) begin
      check("run_rnd", rnd_o, k);
      check("run_busy", busy_o, 1);
      check("run_cfg", round_config_o, cfg);
      check("run_done", done_valid_o, 0);
      check("run_ready", start_ready_o, 0);
      exp[63:0]   = exp[63:0] + 64'd1;
      exp[127:64] = exp[127:64] ^ 64'(k);
      if (toggle && k == 3) round_config_i = ~cfg;
      @(negedge clk_i);
    end
    check("done_valid", done_valid_o, 1);
    check("done_busy", busy_o, 0);
    check("done_rnd", rnd_o, 0);
    check("done_state", state_o, exp);
    check("done_rstate", round_state_o, exp);
  endtask

  task automatic finish_handshake();
    done_ready_i = 1'b1;
    @(negedge clk_i);
    done_ready_i = 1'b0;
    check("hs_done", done_valid_o, 0);
    check("hs_ready", start_ready_o, 1);
    check("hs_busy", busy_o, 0);
  endtask

  logic [319:0] exp_s;
  logic [319:0] pat_a;
  logic [319:0] pat_b;
  bit           seen;

  initial begin
    rst_i          = 1'b1;
    start_valid_i  = 1'b0;
    round_config_i = 1'b0;
    state_i        = '0;
    done_ready_i   = 1'b0;
    pat_a = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc,
             64'h0000_0000_0000_00a5, 64'h0000_0000_0000_0100};
    pat_b = {64'hdead_beef_0000_0001, 64'h0123_4567_89ab_cdef, 64'hffff_0000_ffff_0000,
             64'h0000_0000_0000_000f, 64'hffff_ffff_ffff_fff8};
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("rst");
    done_ready_i = 1'b1;
    rst_i = 1'b0;
    @(negedge clk_i);
    done_ready_i = 1'b0;
    check_reset_outputs("post_rst");

    // p12 from zero: word0=12, word1=0.
    run_perm(1'b1, '0, 1'b0, exp_s);
    check("p12_word0", state_o[63:0], 64'd12);
    check("p12_word1", state_o[127:64], 64'd0);

    // Backpressure: result held, start requests refused.
    for (int i = 0; i < 5; i++) begin
      start_valid_i = 1'b1;
      state_i       = pat_b;
      @(negedge clk_i);
      check("bp_valid", done_valid_o, 1);
      check("bp_state", state_o, exp_s);
      check("bp_ready", start_ready_o, 0);
      check("bp_busy", busy_o, 0);
    end
    start_valid_i = 1'b0;
    state_i       = '0;
    finish_handshake();

    // p8 from a pattern: word0 +8, word1 ^ 0.
    run_perm(1'b0, pat_a, 1'b0, exp_s);
    check("p8_word0", state_o[63:0], 64'h108);
    check("p8_word1", state_o[127:64], 64'ha5);
    check("p8_upper", state_o[319:128], pat_a[319:128]);
    finish_handshake();

    // Config toggled mid-run: still 12 rounds; word0 wraps from ...fff8 to 4.
    run_perm(1'b1, pat_b, 1'b1, exp_s);
    check("tog_word0", state_o[63:0], 64'd4);
    check("tog_word1", state_o[127:64], 64'hf);

    // Simultaneous done and start handshake.
    done_ready_i   = 1'b1;
    start_valid_i  = 1'b1;
    round_config_i = 1'b0;
    state_i        = '0;
`ifdef ASCON_ROUND_CTRL_BACK2BACK_EN
    check("b2b_ready_in_done", start_ready_o, 1);
    @(negedge clk_i);
    done_ready_i  = 1'b0;
    start_valid_i = 1'b0;
    check("b2b_busy", busy_o, 1);
    check("b2b_rnd", rnd_o, 0);
    check("b2b_done", done_valid_o, 0);
`else
    check("b2b_ready_in_done", start_ready_o, 0);
    @(negedge clk_i);
    done_ready_i = 1'b0;
    check("b2b_idle_busy", busy_o, 0);
    check("b2b_idle_ready", start_ready_o, 1);
    check("b2b_idle_done", done_valid_o, 0);
    @(negedge clk_i);
    start_valid_i = 1'b0;
    check("b2b_busy", busy_o, 1);
    check("b2b_rnd", rnd_o, 0);
`endif
    check("b2b_cfg", round_config_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      seen = done_valid_o;
    end
    check("b2b_done_seen", seen, 1);
    check("b2b_word0", state_o[63:0], 64'd8);
    finish_handshake();

    // Reset at round 5 of a p12 run.
    start_valid_i  = 1'b1;
    round_config_i = 1'b1;
    state_i        = pat_a;
    @(negedge clk_i);
    start_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk_i);
    check("mid_rnd5", rnd_o, 5);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_outputs("mid_rst");
    @(negedge clk_i);
    check("mid_no_done", done_valid_o, 0);
    run_perm(1'b1, '0, 1'b0, exp_s);
    check("fresh_word0", state_o[63:0], 64'd12);
    finish_handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
